// File: rtl/clk_edge_monitor_pkg.sv
// Shared state encoding, default sizing and helpers for the slow-clock edge monitor.
package clk_edge_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2,
        ST_LOST    = 2'd3
    } state_e;

    localparam int DEF_CNT_W   = 16;
    localparam int DEF_TIMEOUT = 1000;

    // True when two successive periods differ by no more than tol cycles.
    function automatic logic period_stable(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input int unsigned tol);
        logic [31:0] diff;
        diff = (a >= b) ? (a - b) : (b - a);
        return (diff <= tol);
    endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchronizer for a single asynchronous bit; all stages reset to 0.
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                always_ff @(posedge clk_i or posedge rst_i) begin
                    if (rst_i) sync_q[gi] <= 1'b0;
                    else       sync_q[gi] <= d_i;
                end
            end else begin : g_next
                always_ff @(posedge clk_i or posedge rst_i) begin
                    if (rst_i) sync_q[gi] <= 1'b0;
                    else       sync_q[gi] <= sync_q[gi-1];
                end
            end
        end
    endgenerate

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/clk_edge_monitor.sv
// Edge ticks, period measurement, lock and loss detection for a divided clock sampled as data.
// Optional high-phase measurement is built when CLK_EDGE_MONITOR_DUTY_EN is defined.
module clk_edge_monitor
    import clk_edge_monitor_pkg::*;
#(
    parameter int          SYNC_STAGES = 2,
    parameter int          CNT_W       = DEF_CNT_W,
    parameter int          TIMEOUT     = DEF_TIMEOUT,
    parameter int unsigned TOL         = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_slow_clk,
    output logic             o_rise_tick,
    output logic             o_fall_tick,
    output logic [CNT_W-1:0] o_period,
    output logic             o_period_vld,
    output logic             o_locked,
    output logic             o_lost,
    output logic [CNT_W-1:0] o_high_time
);

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    logic             s;
    logic             s_d_q;
    logic             rise;
    logic             fall;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] period_q;
    logic             period_vld_q;
    logic             prev_vld_q;
    logic             rise_tick_q;
    logic             fall_tick_q;
    logic             locked_q;
    logic             lost_q;
    logic             timeout_hit;
    logic             stable;
    state_e           state_q;

    sync_bit #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_i(i_clk),
        .rst_i(i_rst),
        .d_i  (i_slow_clk),
        .q_o  (s)
    );

    assign rise = s & ~s_d_q;
    assign fall = ~s & s_d_q;

    // Counts cycles since the last rise; loading 1 makes a period of N read back as N.
    always_comb begin
        cnt_d = cnt_q;
        if (rise)                 cnt_d = CNT_W'(1);
        else if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
    end

    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TIMEOUT_C);
    assign stable      = prev_vld_q && period_stable(32'(cnt_q), 32'(period_q), TOL);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s_d_q        <= 1'b0;
            rise_tick_q  <= 1'b0;
            fall_tick_q  <= 1'b0;
            cnt_q        <= '0;
            period_q     <= '0;
            period_vld_q <= 1'b0;
            prev_vld_q   <= 1'b0;
            locked_q     <= 1'b0;
            lost_q       <= 1'b0;
            state_q      <= ST_IDLE;
        end else begin
            s_d_q        <= s;
            rise_tick_q  <= rise;
            fall_tick_q  <= fall;
            cnt_q        <= cnt_d;
            period_vld_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (rise) begin
                        state_q    <= ST_MEASURE;
                        prev_vld_q <= 1'b0;
                    end
                end
                ST_MEASURE, ST_LOCKED: begin
                    // A rise on the timeout cycle takes priority over loss.
                    if (rise) begin
                        period_q     <= cnt_q;
                        period_vld_q <= 1'b1;
                        prev_vld_q   <= 1'b1;
                        if (stable) begin
                            state_q  <= ST_LOCKED;
                            locked_q <= 1'b1;
                        end else begin
                            state_q  <= ST_MEASURE;
                            locked_q <= 1'b0;
                        end
                    end else if (timeout_hit) begin
                        state_q  <= ST_LOST;
                        locked_q <= 1'b0;
                        lost_q   <= 1'b1;
                    end
                end
                ST_LOST: begin
                    if (rise) begin
                        state_q    <= ST_MEASURE;
                        lost_q     <= 1'b0;
                        prev_vld_q <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_rise_tick  = rise_tick_q;
    assign o_fall_tick  = fall_tick_q;
    assign o_period     = period_q;
    assign o_period_vld = period_vld_q;
    assign o_locked     = locked_q;
    assign o_lost       = lost_q;

`ifdef CLK_EDGE_MONITOR_DUTY_EN
    logic [CNT_W-1:0] high_cnt_q;
    logic [CNT_W-1:0] high_cnt_d;
    logic [CNT_W-1:0] high_time_q;

    always_comb begin
        high_cnt_d = high_cnt_q;
        if (rise)                           high_cnt_d = CNT_W'(1);
        else if (s && high_cnt_q != CNT_MAX) high_cnt_d = high_cnt_q + 1'b1;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            high_cnt_q  <= '0;
            high_time_q <= '0;
        end else begin
            high_cnt_q <= high_cnt_d;
            if (fall) high_time_q <= high_cnt_q;
        end
    end

    assign o_high_time = high_time_q;
`else
    assign o_high_time = '0;
`endif

endmodule

// File: tb/tb_clk_edge_monitor.sv
// Scoreboard bench: a TIMEOUT=64 monitor for tick/lock/loss/reset/duty, and an 8-bit TIMEOUT=0 monitor for saturation.
module tb_clk_edge_monitor;

`ifdef CLK_EDGE_MONITOR_DUTY_EN
    localparam bit DUTY = 1'b1;
`else
    localparam bit DUTY = 1'b0;
`endif
    localparam int TO      = 64;
    localparam int LOST_AT = 3 + TO - 14;

    typedef struct {
        int period;
        bit locked;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        slow;
    logic        rise_tick, fall_tick, period_vld, locked, lost;
    logic [15:0] period, high_time;

    logic        rst2;
    logic        slow2;
    logic        rise_tick2, fall_tick2, period_vld2, locked2, lost2;
    logic [7:0]  period2, high_time2;

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];
    int   exp2_q[$];

    always #5 clk = ~clk;

    clk_edge_monitor #(
        .SYNC_STAGES(2), .CNT_W(16), .TIMEOUT(TO), .TOL(1)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_slow_clk(slow),
        .o_rise_tick(rise_tick), .o_fall_tick(fall_tick),
        .o_period(period), .o_period_vld(period_vld),
        .o_locked(locked), .o_lost(lost), .o_high_time(high_time)
    );

    clk_edge_monitor #(
        .SYNC_STAGES(2), .CNT_W(8), .TIMEOUT(0), .TOL(1)
    ) dut_sat (
        .i_clk(clk), .i_rst(rst2), .i_slow_clk(slow2),
        .o_rise_tick(rise_tick2), .o_fall_tick(fall_tick2),
        .o_period(period2), .o_period_vld(period_vld2),
        .o_locked(locked2), .o_lost(lost2), .o_high_time(high_time2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // One slow-clock cycle starting just after a posedge; rise pushes the expectation for the interval just ended.
    task automatic slow_cycle(input int high, input int low, input bit exp_vld,
                              input int exp_period, input bit exp_locked, input bit lost_before);
        int p;
        exp_t e;
        p = high + low;
        slow = 1'b1;
        if (exp_vld) begin
            e.period = exp_period;
            e.locked = exp_locked;
            exp_q.push_back(e);
        end
        for (int j = 0; j < p; j++) begin
            @(posedge clk); #1;
            if (j == high - 1) slow = 1'b0;
            if (j == 1) check("rise_early", rise_tick, 0);
            if (j == 2) check("rise_tick", rise_tick, 1);
            if (j == 3) check("rise_width", rise_tick, 0);
            if (j == high + 2 && j < p) begin
                check("fall_tick", fall_tick, 1);
                check("high_time", high_time, DUTY ? high : 0);
            end
            if (lost_before && j == 1) check("lost_hold", lost, 1);
            if (lost_before && j == 2) check("lost_clear", lost, 0);
        end
    endtask

    always @(negedge clk) begin
        if (period_vld === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexp_vld", period_vld, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                $display("vld period=%0d locked=%0d (exp %0d/%0d)", period, locked, e.period, e.locked);
                check("period", period, e.period);
                check("locked", locked, e.locked);
                check("vld_with_tick", rise_tick, 1);
                check("no_lost_at_vld", lost, 0);
            end
        end
    end

    always @(negedge clk) begin
        if (period_vld2 === 1'b1) begin
            if (exp2_q.size() == 0) begin
                check("unexp_vld2", period_vld2, 0);
            end else begin
                int ep;
                ep = exp2_q.pop_front();
                $display("vld2 period=%0d lost=%0d (exp %0d)", period2, lost2, ep);
                check("sat_period", period2, ep);
                check("sat_no_lost", lost2, 0);
            end
        end
    end

    initial begin
        #100us;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        rst2  = 1'b1;
        slow  = 1'b0;
        slow2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rise", rise_tick, 0);
        check("rst_fall", fall_tick, 0);
        check("rst_period", period, 0);
        check("rst_vld", period_vld, 0);
        check("rst_locked", locked, 0);
        check("rst_lost", lost, 0);
        check("rst_high", high_time, 0);
        check("rst2_period", period2, 0);
        rst  = 1'b0;
        rst2 = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        fork
            begin
                // Divide-by-10, then switch to 14 while locked.
                slow_cycle(5, 5, 0, 0, 0, 0);
                slow_cycle(5, 5, 1, 10, 0, 0);
                slow_cycle(5, 5, 1, 10, 1, 0);
                slow_cycle(7, 7, 1, 10, 1, 0);
                slow_cycle(7, 7, 1, 14, 0, 0);
                slow_cycle(7, 7, 1, 14, 1, 0);
                // Stop the slow clock and watch for loss.
                for (int m = 1; m <= 60; m++) begin
                    @(posedge clk); #1;
                    check("lost_timing", lost, (m >= LOST_AT) ? 1 : 0);
                    check("locked_timing", locked, (m < LOST_AT) ? 1 : 0);
                end
                check("period_hold_lost", period, 14);
                slow_cycle(5, 5, 0, 0, 0, 1);
                slow_cycle(5, 5, 1, 10, 0, 0);
                slow_cycle(5, 5, 1, 10, 1, 0);
                // Partial cycle then an asynchronous reset mid-period.
                slow_cycle(5, 2, 1, 10, 1, 0);
                #2;
                rst = 1'b1;
                #1;
                check("arst_rise", rise_tick, 0);
                check("arst_fall", fall_tick, 0);
                check("arst_period", period, 0);
                check("arst_vld", period_vld, 0);
                check("arst_locked", locked, 0);
                check("arst_lost", lost, 0);
                check("arst_high", high_time, 0);
                repeat (3) @(posedge clk);
                #2;
                rst = 1'b0;
                repeat (4) @(posedge clk);
                #1;
                slow_cycle(5, 5, 0, 0, 0, 0);
                slow_cycle(5, 5, 1, 10, 0, 0);
                slow_cycle(5, 5, 1, 10, 1, 0);
                // 3 high / 7 low for the high-phase measurement.
                slow_cycle(3, 7, 1, 10, 1, 0);
                slow_cycle(3, 7, 1, 10, 1, 0);
                slow_cycle(3, 7, 1, 10, 1, 0);
                repeat (6) @(posedge clk);
                #1;
            end
            begin
                for (int r = 0; r < 3; r++) begin
                    slow2 = 1'b1;
                    if (r >= 1) exp2_q.push_back(255);
                    repeat (150) @(posedge clk);
                    #1;
                    slow2 = 1'b0;
                    repeat (150) @(posedge clk);
                    #1;
                end
                repeat (10) @(posedge clk);
                #1;
            end
        join

        check("exp_q_drained", exp_q.size(), 0);
        check("exp2_q_drained", exp2_q.size(), 0);
        check("sat_period_hold", period2, 255);
        check("sat_never_lost", lost2, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
